// File: rtl/serial_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : serial_bus_slave
// Brief    : Bit-serial bus responder with local byte memory (LSB-first frames)
// Revision : 1.0
// ============================================================================
module serial_bus_slave #(
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic mvalid,
    input  logic mmode,
    input  logic mwdata,
    output logic sready,
    output logic svalid,
    output logic srdata
);

    localparam int C_CNT_MAX = (SLAVE_MEM_ADDR_WIDTH > DATA_WIDTH) ? SLAVE_MEM_ADDR_WIDTH : DATA_WIDTH;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_DEPTH   = 2 ** SLAVE_MEM_ADDR_WIDTH;

    localparam logic [C_CNT_W-1:0] C_ADDR_LAST = C_CNT_W'(SLAVE_MEM_ADDR_WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_DATA_LAST = C_CNT_W'(DATA_WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_ZERO  = '0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RFETCH = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;

    logic [2:0]                      r_state;
    logic [2:0]                      w_next;
    logic [C_CNT_W-1:0]              r_cnt;
    logic [C_CNT_W-1:0]              w_cnt_next;
    logic                            r_mode;
    logic [SLAVE_MEM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]           r_wdata;
    logic [DATA_WIDTH-1:0]           r_shift;
    logic [DATA_WIDTH-1:0]           w_rd_word;
    logic                            r_sready;
    logic                            r_svalid;
    logic                            r_srdata;
    logic                            w_start;
    logic [DATA_WIDTH-1:0]           r_mem [C_DEPTH];

    assign sready    = r_sready;
    assign svalid    = r_svalid;
    assign srdata    = r_srdata;
    assign w_start   = (r_state == S_IDLE) && mvalid && r_sready;
    assign w_rd_word = r_mem[r_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next     = S_ADDR;
                    w_cnt_next = C_CNT_ONE;
                end
            end
            S_ADDR: begin
                if (mvalid) begin
                    if (r_cnt == C_ADDR_LAST) begin
                        w_next     = r_mode ? S_WDATA : S_RFETCH;
                        w_cnt_next = C_CNT_ZERO;
                    end else begin
                        w_cnt_next = r_cnt + C_CNT_ONE;
                    end
                end
            end
            S_WDATA: begin
                if (mvalid) begin
                    if (r_cnt == C_DATA_LAST) begin
                        w_next     = S_WRITE;
                        w_cnt_next = C_CNT_ZERO;
                    end else begin
                        w_cnt_next = r_cnt + C_CNT_ONE;
                    end
                end
            end
            S_WRITE: begin
                w_next = S_IDLE;
            end
            S_RFETCH: begin
                w_next     = S_RDATA;
                w_cnt_next = C_CNT_ZERO;
            end
            S_RDATA: begin
                if (r_cnt == C_DATA_LAST) begin
                    w_next     = S_IDLE;
                    w_cnt_next = C_CNT_ZERO;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = C_CNT_ZERO;
            end
        endcase
    end

    // Output flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= C_CNT_ZERO;
            r_sready <= 1'b1;
            r_svalid <= 1'b0;
            r_srdata <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_sready <= (w_next == S_IDLE);
            r_svalid <= (w_next == S_RDATA);
            if (r_state == S_RFETCH) begin
                r_srdata <= w_rd_word[0];
            end else if ((r_state == S_RDATA) && (w_next == S_RDATA)) begin
                r_srdata <= r_shift[0];
            end else begin
                r_srdata <= 1'b0;
            end
        end
    end

    // Address and data shift in at the top so the first (LSB) bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_mode <= mmode;
        end
        if (w_start || ((r_state == S_ADDR) && mvalid)) begin
            r_addr <= {mwdata, r_addr[SLAVE_MEM_ADDR_WIDTH-1:1]};
        end
        if ((r_state == S_WDATA) && mvalid) begin
            r_wdata <= {mwdata, r_wdata[DATA_WIDTH-1:1]};
        end
        if (r_state == S_RFETCH) begin
            r_shift <= w_rd_word >> 1;
        end else if (r_state == S_RDATA) begin
            r_shift <= r_shift >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_WRITE) && !rst) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bus_slave
// Brief    : Self-checking bench for serial_bus_slave (vectors, directed, random)
// Revision : 1.0
// ============================================================================
module tb_serial_bus_slave;

    localparam int DW = 8;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst;
    logic mvalid;
    logic mmode;
    logic mwdata;
    logic sready;
    logic svalid;
    logic srdata;

    int checks = 0;
    int errors = 0;

    // Reference model: the memory contents implied by completed writes.
    logic [DW-1:0] mdl [int];
    int            wr_q [$];

    typedef struct packed {
        logic rst;
        logic mvalid;
        logic mmode;
        logic mwdata;
        logic sready;
        logic svalid;
        logic srdata;
    } vec_t;

    serial_bus_slave #(
        .DATA_WIDTH           (DW),
        .SLAVE_MEM_ADDR_WIDTH (AW)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .mvalid (mvalid),
        .mmode  (mmode),
        .mwdata (mwdata),
        .sready (sready),
        .svalid (svalid),
        .srdata (srdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sends n bits LSB first, optionally stalling st_n cycles after bit st_after.
    task automatic send_serial(input logic [15:0] val, input int n, input int st_after, input int st_n);
        int ns;
        for (int i = 0; i < n; i++) begin
            mvalid = 1'b1;
            mwdata = val[i];
            tick;
            mmode = 1'($urandom);
            check("busy", 32'(sready), 32'd0);
            ns = ((i == st_after) && (i < n - 1)) ? st_n : 0;
            for (int k = 0; k < ns; k++) begin
                mvalid = 1'b0;
                mwdata = 1'($urandom);
                tick;
                check("stall_busy", 32'(sready), 32'd0);
                check("stall_svalid", 32'(svalid), 32'd0);
            end
        end
    endtask

    task automatic start_and_addr(input logic mode, input logic [AW-1:0] a, input int sa, input int sna);
        check("start_ready", 32'(sready), 32'd1);
        mmode = mode;
        send_serial(16'(a), AW, sa, sna);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int sa, input int sna, input int sd, input int snd);
        start_and_addr(1'b1, a, sa, sna);
        send_serial(16'(d), DW, sd, snd);
        mvalid = 1'b0;
        tick;
        check("wr_ready_t2", 32'(sready), 32'd1);
        check("wr_svalid", 32'(svalid), 32'd0);
        mdl[int'(a)] = d;
        wr_q.push_back(int'(a));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic hold, input int sa, input int sna);
        logic [DW-1:0] got;
        got = '0;
        start_and_addr(1'b0, a, sa, sna);
        check("rfetch_svalid", 32'(svalid), 32'd0);
        for (int i = 0; i < DW; i++) begin
            mvalid = hold;
            mwdata = 1'($urandom);
            tick;
            check("rd_svalid", 32'(svalid), 32'd1);
            check("rd_busy", 32'(sready), 32'd0);
            got[i] = srdata;
        end
        mvalid = hold;
        mwdata = 1'($urandom);
        tick;
        check("rd_end_svalid", 32'(svalid), 32'd0);
        check("rd_end_srdata", 32'(srdata), 32'd0);
        check("rd_end_ready", 32'(sready), 32'd1);
        if (mdl.exists(int'(a))) begin
            check("rd_data", 32'(got), 32'(mdl[int'(a)]));
        end else begin
            errors++;
            $display("FAIL rd_model: address %0h read before being written", a);
        end
    endtask

    initial begin
        vec_t vecs [8];
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int            sel;

        rst    = 1'b1;
        mvalid = 1'b0;
        mmode  = 1'b0;
        mwdata = 1'b0;

        //          rst   mvalid mmode mwdata sready svalid srdata
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            rst    = vecs[v].rst;
            mvalid = vecs[v].mvalid;
            mmode  = vecs[v].mmode;
            mwdata = vecs[v].mwdata;
            tick;
            check($sformatf("vec%0d_sready", v), 32'(sready), 32'(vecs[v].sready));
            check($sformatf("vec%0d_svalid", v), 32'(svalid), 32'(vecs[v].svalid));
            check($sformatf("vec%0d_srdata", v), 32'(srdata), 32'(vecs[v].srdata));
        end

        // Basic write then read.
        do_write(12'h123, 8'hA5, -1, 0, -1, 0);
        do_read(12'h123, 1'b0, -1, 0);

        // Stalls inside address and data frames.
        do_write(12'hFFF, 8'h3C, 5, 3, 3, 2);
        do_read(12'hFFF, 1'b0, -1, 0);

        // Boundary addresses without aliasing.
        do_write(12'h000, 8'h01, -1, 0, -1, 0);
        do_write(12'hFFF, 8'h80, -1, 0, -1, 0);
        do_read(12'h000, 1'b0, -1, 0);
        do_read(12'hFFF, 1'b0, -1, 0);

        // Reset after data bit 5 of a write must leave memory untouched.
        do_write(12'h010, 8'h55, -1, 0, -1, 0);
        start_and_addr(1'b1, 12'h010, -1, 0);
        send_serial(16'h00FF, 6, -1, 0);
        rst    = 1'b1;
        mvalid = 1'b1;
        tick;
        check("midrst_ready", 32'(sready), 32'd1);
        check("midrst_svalid", 32'(svalid), 32'd0);
        rst    = 1'b0;
        mvalid = 1'b0;
        tick;
        check("postrst_ready", 32'(sready), 32'd1);
        do_read(12'h010, 1'b0, -1, 0);

        // mvalid held high through a read; next write starts in the first ready cycle.
        do_read(12'h123, 1'b1, -1, 0);
        do_write(12'h001, 8'h0F, -1, 0, -1, 0);
        do_read(12'h001, 1'b0, -1, 0);

        // Randomized traffic against the memory model.
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 99));
            if ((wr_q.size() == 0) || (sel < 45)) begin
                if ((wr_q.size() != 0) && ($urandom_range(0, 1) == 1)) begin
                    ra = AW'(wr_q[$urandom_range(0, wr_q.size() - 1)]);
                end else begin
                    ra = AW'($urandom);
                end
                rd = DW'($urandom);
                do_write(ra, rd, int'($urandom_range(0, AW - 1)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, DW - 1)), int'($urandom_range(0, 3)));
            end else begin
                ra = AW'(wr_q[$urandom_range(0, wr_q.size() - 1)]);
                do_read(ra, 1'($urandom), int'($urandom_range(0, AW - 1)), int'($urandom_range(0, 3)));
            end
        end

        mvalid = 1'b0;
        tick;
        tick;
        check("final_idle", 32'(sready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
